// File: rtl/interleaver_block_sched_if.sv
// Block request, byte stream and interleaver-side bundle for interleaver_block_sched.
// master is the controller side; slave is the upstream/interleaver side.
interface interleaver_block_sched_if;
   logic       blk_req;
   logic       blk_size;
   logic       blk_ack;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] il_data;
   logic       il_data_valid;
   logic       il_crc_start;
   logic       il_crc_blocksize;
   logic       il_crc_end;
   logic [7:0] il_data_out;
   logic       il_data_ready;
   logic       il_done;
   logic [7:0] out_data;
   logic       out_valid;
   logic       blk_done;
   logic       busy;
   logic       timeout_err;
   logic       count_err;

   modport master (
      input  blk_req,
      input  blk_size,
      input  in_data,
      input  in_valid,
      input  il_data_out,
      input  il_data_ready,
      input  il_done,
      output blk_ack,
      output in_ready,
      output il_data,
      output il_data_valid,
      output il_crc_start,
      output il_crc_blocksize,
      output il_crc_end,
      output out_data,
      output out_valid,
      output blk_done,
      output busy,
      output timeout_err,
      output count_err
   );

   modport slave (
      output blk_req,
      output blk_size,
      output in_data,
      output in_valid,
      output il_data_out,
      output il_data_ready,
      output il_done,
      input  blk_ack,
      input  in_ready,
      input  il_data,
      input  il_data_valid,
      input  il_crc_start,
      input  il_crc_blocksize,
      input  il_crc_end,
      input  out_data,
      input  out_valid,
      input  blk_done,
      input  busy,
      input  timeout_err,
      input  count_err
   );
endinterface

// File: rtl/interleaver_block_sched.sv
// Block sequencer in front of the byte-wide turbo interleaver: loads one
// block, waits for the interleaver with a watchdog, checks the returned count.
module interleaver_block_sched #(
   parameter int SMALL_BYTES    = 132,
   parameter int LARGE_BYTES    = 768,
   parameter int CNT_W          = 10,
   parameter int TIMEOUT_CYCLES = 8192,
   parameter int TO_W           = 14
) (
   input logic                      clk,
   input logic                      reset,
   interleaver_block_sched_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] SMALL_N = CNT_W'(SMALL_BYTES);
   localparam logic [CNT_W-1:0] LARGE_N = CNT_W'(LARGE_BYTES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TO_W-1:0]  WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] size;
   logic [TO_W-1:0]  wd;
   logic             first;
   logic             blksize_q;
   logic             accept;
   logic             xfer;
   logic             last_xfer;
   logic             wd_expired;

   logic [7:0]       il_data_q;
   logic             il_valid_q;
   logic             crc_start_q;
   logic             crc_end_q;
   logic [7:0]       out_data_q;
   logic             out_valid_q;
   logic             timeout_q;
   logic             count_q;

   assign size       = blksize_q ? LARGE_N : SMALL_N;
   assign wd_expired = (wd == WD_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      xfer      = 1'b0;
      last_xfer = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.blk_req) begin
               accept   = 1'b1;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            if (bus.in_valid) begin
               xfer = 1'b1;
               if (in_cnt == '0) begin
                  last_xfer = 1'b1;
                  state_nx  = RUN;
               end
            end
         end
         RUN: begin
            // done takes priority over a watchdog expiring in the same cycle
            if (bus.il_done || wd_expired) state_nx = DONE;
         end
         DONE: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blksize_q   <= 1'b0;
         in_cnt      <= '0;
         first       <= 1'b0;
         il_data_q   <= '0;
         il_valid_q  <= 1'b0;
         crc_start_q <= 1'b0;
         crc_end_q   <= 1'b0;
      end else begin
         il_valid_q  <= 1'b0;
         crc_start_q <= 1'b0;
         crc_end_q   <= 1'b0;
         if (accept) begin
            blksize_q <= bus.blk_size;
            in_cnt    <= (bus.blk_size ? LARGE_N : SMALL_N) - 1'b1;
            first     <= 1'b1;
         end
         if (xfer) begin
            il_data_q   <= bus.in_data;
            il_valid_q  <= 1'b1;
            crc_start_q <= first;
            crc_end_q   <= (in_cnt == '0);
            first       <= 1'b0;
            if (in_cnt != '0) in_cnt <= in_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // returned bytes are forwarded in every state, counted only in RUN
         out_valid_q <= bus.il_data_ready;
         if (bus.il_data_ready) out_data_q <= bus.il_data_out;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_cnt <= '0;
         wd      <= '0;
      end else if (last_xfer) begin
         out_cnt <= '0;
         wd      <= '0;
      end else if (state == RUN) begin
         if (bus.il_data_ready && out_cnt != CNT_MAX) out_cnt <= out_cnt + 1'b1;
         if (!wd_expired) wd <= wd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_q <= 1'b0;
         count_q   <= 1'b0;
      end else begin
         if (state == RUN && !bus.il_done && wd_expired) timeout_q <= 1'b1;
         if (state == DONE && out_cnt != size) count_q <= 1'b1;
      end
   end

   assign bus.blk_ack          = accept & ~reset;
   assign bus.in_ready         = (state == LOAD);
   assign bus.busy             = (state != IDLE);
   assign bus.blk_done         = (state == DONE);
   assign bus.il_data          = il_data_q;
   assign bus.il_data_valid    = il_valid_q;
   assign bus.il_crc_start     = crc_start_q;
   assign bus.il_crc_end       = crc_end_q;
   assign bus.il_crc_blocksize = blksize_q;
   assign bus.out_data         = out_data_q;
   assign bus.out_valid        = out_valid_q;
   assign bus.timeout_err      = timeout_q;
   assign bus.count_err        = count_q;

endmodule

// File: tb/tb_interleaver_block_sched.sv
// Scoreboard bench for interleaver_block_sched: loads blocks, plays the
// interleaver, and checks strobes, returned bytes, watchdog and count errors.
module tb_interleaver_block_sched;

   localparam int SMALL = 132;
   localparam int LARGE = 768;
   localparam int TO    = 8192;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   interleaver_block_sched_if bus ();

   interleaver_block_sched dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [10:0] il_q[$];
   logic [7:0]  out_q[$];
   int          idx     = 0;
   int          blk_n   = SMALL;
   logic        bs      = 1'b0;
   int          n_ilv   = 0;
   int          n_st    = 0;
   int          n_en    = 0;
   int          n_done  = 0;
   int          run_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [26:0] outs();
      return {bus.blk_ack, bus.in_ready, bus.il_data, bus.il_data_valid,
              bus.il_crc_start, bus.il_crc_blocksize, bus.il_crc_end,
              bus.out_data, bus.out_valid, bus.blk_done, bus.busy,
              bus.timeout_err, bus.count_err};
   endfunction

   always @(negedge clk) begin
      logic [10:0] e;
      logic [7:0]  o;
      if (bus.il_data_valid) begin
         chk("il_q_nonempty", 32'(il_q.size() != 0), 1);
         if (il_q.size() != 0) begin
            e = il_q.pop_front();
            chk("il_byte", {bus.il_crc_blocksize, bus.il_crc_start,
                            bus.il_crc_end, bus.il_data}, e);
         end
         n_ilv++;
      end
      n_st += int'(bus.il_crc_start);
      n_en += int'(bus.il_crc_end);
      if (bus.out_valid) begin
         chk("out_q_nonempty", 32'(out_q.size() != 0), 1);
         if (out_q.size() != 0) begin
            o = out_q.pop_front();
            chk("out_byte", bus.out_data, o);
         end
      end
      if (bus.blk_done) n_done++;
      if (bus.busy && !bus.in_ready && !bus.blk_done) run_cyc++;
      if (bus.blk_ack) begin
         idx     = 0;
         blk_n   = bus.blk_size ? LARGE : SMALL;
         bs      = bus.blk_size;
         n_ilv   = 0;
         n_st    = 0;
         n_en    = 0;
         n_done  = 0;
         run_cyc = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
         il_q.push_back({bs, idx == 0, idx == blk_n - 1, bus.in_data});
         idx++;
      end
      if (bus.il_data_ready) out_q.push_back(bus.il_data_out);
      if (reset) begin
         il_q.delete();
         out_q.delete();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input logic sz);
      bit got = 1'b0;
      tick();
      bus.blk_req  = 1'b1;
      bus.blk_size = sz;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.blk_ack) begin
            got = 1'b1;
            break;
         end
      end
      chk("ack_wait", 32'(got), 1);
      tick();
      bus.blk_req = 1'b0;
   endtask

   task automatic send_block(input int n, input bit toggle);
      int i = 0;
      int c = 0;
      while (i < n && c < 4000) begin
         tick();
         if (toggle && c[0]) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = i[7:0];
         end
         c++;
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) i++;
      end
      chk("send_cnt", i, n);
   endtask

   task automatic ret_bytes(input int n, input bit done_last,
                            input bit give_done);
      for (int k = 0; k < n; k++) begin
         tick();
         bus.il_data_ready = 1'b1;
         bus.il_data_out   = 8'hA5 ^ k[7:0];
         bus.il_done       = done_last && (k == n - 1);
      end
      if (!done_last && give_done) begin
         tick();
         bus.il_data_ready = 1'b0;
         bus.il_done       = 1'b1;
      end
      tick();
      bus.il_data_ready = 1'b0;
      bus.il_done       = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      bit ok = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_wait", 32'(ok), 1);
   endtask

   task automatic do_reset();
      tick();
      reset             = 1'b1;
      bus.blk_req       = 1'b0;
      bus.in_valid      = 1'b0;
      bus.il_data_ready = 1'b0;
      bus.il_done       = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_clear", {bus.timeout_err, bus.count_err, bus.busy}, 0);
   endtask

   task automatic end_load();
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      reset             = 1'b1;
      bus.blk_req       = 1'b1;
      bus.blk_size      = 1'b0;
      bus.in_data       = '0;
      bus.in_valid      = 1'b0;
      bus.il_data_out   = '0;
      bus.il_data_ready = 1'b0;
      bus.il_done       = 1'b0;

      // 1: reset with a pending request, then accept a small block
      repeat (3) begin
         tick();
         @(negedge clk);
         chk("rst_outs", outs(), 0);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("first_ack", bus.blk_ack, 1);
      tick();
      bus.blk_req = 1'b0;
      @(negedge clk);
      chk("post_ack", {bus.blk_ack, bus.il_crc_blocksize, bus.busy}, 3'b001);

      // 2: gap-free small block, full return then done
      send_block(SMALL, 1'b0);
      end_load();
      bus.blk_req = 1'b1;
      @(negedge clk);
      chk("ack_busy", bus.blk_ack, 0);
      tick();
      bus.blk_req = 1'b0;
      ret_bytes(SMALL, 1'b0, 1'b1);
      wait_idle(400);
      chk("s_ilv", n_ilv, SMALL);
      chk("s_strobes", {n_st[7:0], n_en[7:0]}, 16'h0101);
      chk("s_done", n_done, 1);
      chk("s_errs", {bus.timeout_err, bus.count_err}, 0);
      chk("s_q_empty", il_q.size() + out_q.size(), 0);

      // 3: large block with in_valid toggling
      start_block(1'b1);
      send_block(LARGE, 1'b1);
      end_load();
      ret_bytes(LARGE, 1'b0, 1'b1);
      wait_idle(2000);
      chk("l_ilv", n_ilv, LARGE);
      chk("l_strobes", {n_st[7:0], n_en[7:0]}, 16'h0101);
      chk("l_errs", {bus.timeout_err, bus.count_err}, 0);
      chk("l_blocksize", bus.il_crc_blocksize, 1);

      // 4: interleaver never finishes
      start_block(1'b0);
      send_block(SMALL, 1'b0);
      end_load();
      wait_idle(TO + 100);
      chk("to_run_cycles", run_cyc, TO);
      chk("to_err", bus.timeout_err, 1);
      chk("to_done", n_done, 1);
      start_block(1'b0);
      do_reset();

      // 5a: one byte short
      start_block(1'b0);
      send_block(SMALL, 1'b0);
      end_load();
      ret_bytes(SMALL - 1, 1'b0, 1'b1);
      wait_idle(400);
      chk("short_cnt_err", bus.count_err, 1);
      chk("short_to_err", bus.timeout_err, 0);
      do_reset();

      // 5b: last byte arrives together with done
      start_block(1'b0);
      send_block(SMALL, 1'b0);
      end_load();
      ret_bytes(SMALL, 1'b1, 1'b1);
      wait_idle(400);
      chk("same_cyc_cnt_err", bus.count_err, 0);
      chk("same_cyc_done", n_done, 1);

      // 6: reset in the middle of a large block
      start_block(1'b1);
      send_block(50, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_mid_outs", outs(), 0);
      tick();
      reset = 1'b0;
      start_block(1'b0);
      send_block(SMALL, 1'b0);
      end_load();
      ret_bytes(SMALL, 1'b0, 1'b1);
      wait_idle(400);
      chk("fresh_ilv", n_ilv, SMALL);
      chk("fresh_errs", {bus.timeout_err, bus.count_err}, 0);
      chk("fresh_done", n_done, 1);
      chk("fresh_q_empty", il_q.size() + out_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
